// File: rtl/bcd_pkg.sv
/*----------------------------------------------------------------------------
 * bcd_pkg : shared constants and state type for the BCD add sequencer
 * Rev 1.0 : initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [DIGIT_W:0] BCD_CORR = 5'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_B  = 3'd1,
    S_ADD     = 3'd2,
    S_CORRECT = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;
endpackage

`default_nettype wire

// File: rtl/bcd_digit_check.sv
/*----------------------------------------------------------------------------
 * bcd_digit_check : flags a digit outside the legal BCD range 0..9
 * Rev 1.0 : initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic               invalid
);

  assign invalid = (digit > MAX_DIGIT);

endmodule

`default_nettype wire

// File: rtl/bcd_add_sequencer.sv
/*----------------------------------------------------------------------------
 * bcd_add_sequencer : captures two BCD digits, adds them with decimal
 *                     correction over two cycles, registered 2-digit result
 * Rev 1.0 : initial release
 *--------------------------------------------------------------------------*/
`default_nettype none

module bcd_add_sequencer
  import bcd_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               load,
  input  logic               clear,
  output logic [DIGIT_W-1:0] sum_tens,
  output logic [DIGIT_W-1:0] sum_ones,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic               op_sel
);

  state_t             state;
  state_t             state_next;
  logic [DIGIT_W-1:0] op_a;
  logic [DIGIT_W-1:0] op_b;
  logic [DIGIT_W:0]   raw;
  logic [DIGIT_W:0]   raw_corr;
  logic               digit_bad;
  logic               load_ok;

  bcd_digit_check u_digit_check (
    .digit   (digit_in),
    .invalid (digit_bad)
  );

  assign load_ok  = load && !digit_bad;
  assign raw_corr = raw + BCD_CORR;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load) state_next = digit_bad ? S_ERR : S_WAIT_B;
        end
        S_WAIT_B: begin
          if (load) state_next = digit_bad ? S_ERR : S_ADD;
        end
        S_ADD:     state_next = S_CORRECT;
        S_CORRECT: state_next = S_DONE;
        S_ERR:     state_next = S_ERR;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status flags are decoded from the upcoming state so they are registered
  // yet line up exactly with the state they describe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      op_sel <= 1'b0;
    end else begin
      valid  <= (state_next == S_DONE);
      busy   <= (state_next == S_ADD) || (state_next == S_CORRECT);
      err    <= (state_next == S_ERR);
      op_sel <= (state_next == S_WAIT_B);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      op_a     <= '0;
      op_b     <= '0;
      raw      <= '0;
      sum_tens <= '0;
      sum_ones <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_ok) op_a <= digit_in;
        end
        S_WAIT_B: begin
          if (load_ok) op_b <= digit_in;
        end
        S_ADD: begin
          raw <= {1'b0, op_a} + {1'b0, op_b};
        end
        S_CORRECT: begin
          if (raw > {1'b0, MAX_DIGIT}) begin
            sum_ones <= raw_corr[DIGIT_W-1:0];
            sum_tens <= 4'd1;
          end else begin
            sum_ones <= raw[DIGIT_W-1:0];
            sum_tens <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
